// File: rtl/ram_burst_ctrl_pkg.sv
// ram_burst_ctrl_pkg
// Shared definitions for the RAM burst controller slice: RAM geometry and
// the controller state encoding.
package ram_burst_ctrl_pkg;

  localparam int RAM_AW = 10;  // 1024 words
  localparam int RAM_DW = 8;   // byte-wide data

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

endpackage

// File: rtl/ram_burst_ctrl_rd_skid.sv
// ram_rd_skid
// Two-entry synchronous FIFO that absorbs read backpressure. Each entry
// carries {last, data}. Push and pop in the same cycle leave the count
// unchanged. The controller never pushes into a full FIFO, because it only
// issues a RAM read when a slot is guaranteed to be free on arrival.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low clear (entries, pointers, count)
//   push       in   write push_data into the tail
//   push_data  in   {last, data}
//   pop        in   drop the head entry
//   head_data  out  {last, data} at the head (stale when count == 0)
//   count      out  number of valid entries, 0..2
module ram_rd_skid #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW:0]   push_data,
  input  logic          pop,
  output logic [DW:0]   head_data,
  output logic [1:0]    count
);

  logic          wr_ptr_reg;
  logic          rd_ptr_reg;
  logic [1:0]    count_reg;
  logic [DW:0]   entries [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      logic [DW:0] entry_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          entry_reg <= '0;
        end else if (push && (wr_ptr_reg == 1'(gi))) begin
          entry_reg <= push_data;
        end
      end

      assign entries[gi] = entry_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_data = entries[rd_ptr_reg];
  assign count     = count_reg;

endmodule

// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl
// Burst command front end for a 1K x 8 single-port RAM with registered
// read data. One read or write burst command is accepted at a time; write
// beats go straight to the RAM pins, read beats come back through a
// 2-entry skid FIFO so the consumer may stall without losing data.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//   cmd_write             1 = write burst, 0 = read burst
//   cmd_addr, cmd_len     start address, beats minus one
//   wr_valid/wr_ready     write-data handshake, wr_data payload
//   rd_valid/rd_ready     read-data handshake, rd_data/rd_last payload
//   busy                  high whenever not IDLE
//   ram_we/ram_addr/ram_din  RAM control pins, ram_dout RAM read data
module ram_burst_ctrl
  import ram_burst_ctrl_pkg::*;
#(
  parameter int AW = RAM_AW,
  parameter int DW = RAM_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW-1:0] cmd_len,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          rd_last,
  output logic          busy,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  state_t        state_reg, state_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [AW-1:0] beats_left_reg, beats_left_next;
  // Set once the final read address of the burst has been issued; the FSM
  // then just drains the FIFO.
  logic          issue_done_reg, issue_done_next;
  logic          inflight_reg;
  logic          inflight_last_reg;

  logic          issue;
  logic          issue_last;
  logic          pop;
  logic [1:0]    fifo_count;
  logic [DW:0]   fifo_head;
  logic [2:0]    occupancy;

  ram_rd_skid #(.DW(DW)) u_rd_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_reg),
    .push_data ({inflight_last_reg, ram_dout}),
    .pop       (pop),
    .head_data (fifo_head),
    .count     (fifo_count)
  );

  assign rd_valid = (fifo_count != 2'd0);
  assign rd_data  = rd_valid ? fifo_head[DW-1:0] : '0;
  assign rd_last  = rd_valid & fifo_head[DW];
  assign pop      = rd_valid & rd_ready;

  // Entries the FIFO will hold after this edge (beats already buffered plus
  // the one arriving from the RAM, minus the one leaving). Issuing only
  // while this is below 2 guarantees a free slot when the new beat lands.
  assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight_reg} - {2'b00, pop};
  assign issue      = (state_reg == READ) && !issue_done_reg && (occupancy < 3'd2);
  assign issue_last = issue && (beats_left_reg == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      addr_reg          <= '0;
      beats_left_reg    <= '0;
      issue_done_reg    <= 1'b0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      addr_reg          <= addr_next;
      beats_left_reg    <= beats_left_next;
      issue_done_reg    <= issue_done_next;
      inflight_reg      <= issue;
      inflight_last_reg <= issue_last;
    end
  end

  always_comb begin
    state_next      = state_reg;
    addr_next       = addr_reg;
    beats_left_next = beats_left_reg;
    issue_done_next = issue_done_reg;

    cmd_ready = (state_reg == IDLE);
    busy      = (state_reg != IDLE);
    wr_ready  = (state_reg == WRITE);
    ram_we    = (state_reg == WRITE) && wr_valid;
    ram_addr  = addr_reg;
    ram_din   = wr_data;

    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          addr_next       = cmd_addr;
          beats_left_next = cmd_len;
          issue_done_next = 1'b0;
          state_next      = cmd_write ? WRITE : READ;
        end
      end

      WRITE: begin
        if (wr_valid) begin
          addr_next = addr_reg + 1'b1;  // wraps modulo 2^AW
          if (beats_left_reg == '0) begin
            state_next = IDLE;
          end else begin
            beats_left_next = beats_left_reg - 1'b1;
          end
        end
      end

      READ: begin
        if (issue) begin
          addr_next = addr_reg + 1'b1;
          if (beats_left_reg == '0) begin
            issue_done_next = 1'b1;
          end else begin
            beats_left_next = beats_left_reg - 1'b1;
          end
        end
        // The last-tagged beat leaving the FIFO ends the burst.
        if (pop && rd_last) begin
          state_next      = IDLE;
          issue_done_next = 1'b0;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
module tb_ram_burst_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [9:0] cmd_addr, cmd_len;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid, rd_ready, rd_last;
  logic [7:0] rd_data;
  logic       busy, ram_we;
  logic [9:0] ram_addr;
  logic [7:0] ram_din, ram_dout;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem    [1024];
  logic [7:0] shadow [1024];
  logic [8:0] exp_q  [$];
  logic [7:0] wdata_q[$];

  always #5 clk = ~clk;

  ram_burst_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  // Coincident single-port RAM with registered read.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  // Offer a command at a falling edge; it is accepted at the next rising
  // edge. Returns at the falling edge just after acceptance.
  task automatic send_cmd(input logic wr, input logic [9:0] a, input logic [9:0] l);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!cmd_ready) begin
      bad++;
      $display("FAIL cmd_accept_timeout: cmd_ready=%0b required 1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic write_burst(input logic [9:0] a, input int gap);
    int nb;
    logic [9:0] exp_a;
    nb = wdata_q.size();
    send_cmd(1'b1, a, 10'(nb - 1));
    exp_a = a;
    for (int i = 0; i < nb; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          wr_valid = 1'b0; wr_data = 8'hEE;
          #1;
          total++;
          if (ram_we !== 1'b0) begin
            bad++;
            $display("FAIL wr_gap_we: ram_we=%0b required 0", ram_we);
          end
          @(negedge clk);
        end
      end
      wr_valid = 1'b1; wr_data = wdata_q[i];
      #1;
      total++;
      if (ram_we !== 1'b1 || wr_ready !== 1'b1 || ram_addr !== exp_a || ram_din !== wdata_q[i]) begin
        bad++;
        $display("FAIL wr_beat%0d: we=%0b rdy=%0b addr=%0d din=%02h required we=1 rdy=1 addr=%0d din=%02h",
                 i, ram_we, wr_ready, ram_addr, ram_din, exp_a, wdata_q[i]);
      end
      shadow[exp_a] = wdata_q[i];
      exp_a = exp_a + 10'd1;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL wr_end: busy=%0b cmd_ready=%0b required busy=0 cmd_ready=1", busy, cmd_ready);
    end
    $display("write burst addr=%0d beats=%0d gap=%0d", a, nb, gap);
    wdata_q.delete();
  endtask

  task automatic read_burst(input logic [9:0] a, input int nb, input bit rand_ready, input bit chk_timing);
    int popped, k, issued;
    logic [9:0] ia, off;
    logic [8:0] e;
    ia = a;
    for (int i = 0; i < nb; i++) begin
      exp_q.push_back({(i == nb - 1), shadow[ia]});
      ia = ia + 10'd1;
    end
    send_cmd(1'b0, a, 10'(nb - 1));
    popped = 0;
    k = 1;
    while (popped < nb && k < 3000) begin
      rd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      off = ram_addr - a;
      issued = int'(off);
      total++;
      if (issued - popped > 2 || issued > nb) begin
        bad++;
        $display("FAIL rd_outstanding: issued=%0d popped=%0d required issued-popped<=2", issued, popped);
      end
      if (chk_timing && (k == 2 || k == 3)) begin
        total++;
        if (rd_valid !== (k == 3)) begin
          bad++;
          $display("FAIL rd_latency: cycle=%0d rd_valid=%0b required %0b", k, rd_valid, (k == 3));
        end
      end
      if (rd_valid && rd_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rd_extra: got data=%02h last=%0b required no beat", rd_data, rd_last);
        end else begin
          e = exp_q.pop_front();
          if ({rd_last, rd_data} !== e) begin
            bad++;
            $display("FAIL rd_beat%0d: data=%02h last=%0b required data=%02h last=%0b",
                     popped, rd_data, rd_last, e[7:0], e[8]);
          end
        end
        popped++;
        if (chk_timing && popped == nb) begin
          total++;
          if (k != nb + 2) begin
            bad++;
            $display("FAIL rd_finish_cycle: last beat at cycle %0d required %0d", k, nb + 2);
          end
        end
      end
      @(negedge clk);
      k++;
    end
    rd_ready = 1'b0;
    #1;
    total++;
    if (popped != nb || busy !== 1'b0 || rd_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL rd_end: beats=%0d busy=%0b rd_valid=%0b cmd_ready=%0b required beats=%0d busy=0 rd_valid=0 cmd_ready=1",
               popped, busy, rd_valid, cmd_ready, nb);
    end
    exp_q.delete();
    $display("read burst addr=%0d beats=%0d random_ready=%0b", a, nb, rand_ready);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wr_valid = 1'b1; wr_data = 8'h3C;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (cmd_ready !== 1'b1 || wr_ready !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 8'h00 ||
        rd_last !== 1'b0 || busy !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 10'd0 || ram_din !== 8'h3C) begin
      bad++;
      $display("FAIL reset_outputs: cr=%0b wrr=%0b rv=%0b rd=%02h rl=%0b busy=%0b we=%0b addr=%0d din=%02h required 1 0 0 00 0 0 0 0 3c",
               cmd_ready, wr_ready, rd_valid, rd_data, rd_last, busy, ram_we, ram_addr, ram_din);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (ram_we !== 1'b0 || wr_ready !== 1'b0) begin
      bad++;
      $display("FAIL idle_wr_ignored: ram_we=%0b wr_ready=%0b required 0 0", ram_we, wr_ready);
    end
    wr_valid = 1'b0;
    $display("reset check done");
  endtask

  task automatic test_single();
    wdata_q.push_back(8'hAA);
    write_burst(10'd21, 0);
    read_burst(10'd21, 1, 1'b0, 1'b1);
  endtask

  task automatic test_wrap();
    wdata_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    write_burst(10'd1022, 0);
    read_burst(10'd1022, 4, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 8; i++) wdata_q.push_back(8'(8'h80 + i));
    write_burst(10'd300, 0);
    read_burst(10'd300, 8, 1'b1, 1'b0);
  endtask

  task automatic test_write_gaps();
    wdata_q = '{8'h5C, 8'h5D, 8'h5E};
    write_burst(10'd228, 2);
    read_burst(10'd228, 3, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_read();
    int popped, n;
    send_cmd(1'b0, 10'd300, 10'd5);
    rd_ready = 1'b1;
    popped = 0;
    n = 0;
    #1;
    while (popped < 2 && n < 100) begin
      if (rd_valid && rd_ready) popped++;
      @(negedge clk);
      #1;
      n++;
    end
    total++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h82) begin
      bad++;
      $display("FAIL mid_read_beat3: rd_valid=%0b rd_data=%02h required 1 82", rd_valid, rd_data);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (rd_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_read_reset: rd_valid=%0b cmd_ready=%0b busy=%0b required 0 1 0", rd_valid, cmd_ready, busy);
    end
    rd_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset during read at beat 3");
    read_burst(10'd21, 1, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    int k, acc, acc1, acc2, popped;
    bit drop;
    logic [8:0] e;
    exp_q.push_back({1'b1, shadow[21]});
    exp_q.push_back({1'b1, shadow[21]});
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'd21; cmd_len = 10'd0;
    rd_ready = 1'b1;
    k = 0; acc = 0; acc1 = -1; acc2 = -1; popped = 0; drop = 1'b0;
    while (popped < 2 && k < 60) begin
      if (drop) cmd_valid = 1'b0;
      #1;
      if (busy) begin
        total++;
        if (cmd_ready !== 1'b0) begin
          bad++;
          $display("FAIL b2b_ready_busy: cmd_ready=%0b required 0 at cycle %0d", cmd_ready, k);
        end
      end
      if (cmd_valid && cmd_ready) begin
        acc++;
        if (acc == 1) acc1 = k;
        else begin
          acc2 = k;
          drop = 1'b1;
        end
      end
      if (rd_valid && rd_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL b2b_extra: data=%02h required no beat", rd_data);
        end else begin
          e = exp_q.pop_front();
          if ({rd_last, rd_data} !== e) begin
            bad++;
            $display("FAIL b2b_beat%0d: data=%02h last=%0b required data=%02h last=%0b",
                     popped, rd_data, rd_last, e[7:0], e[8]);
          end
        end
        popped++;
      end
      @(negedge clk);
      k++;
    end
    cmd_valid = 1'b0;
    rd_ready = 1'b0;
    total++;
    if (acc != 2 || acc2 - acc1 != 4 || popped != 2) begin
      bad++;
      $display("FAIL b2b_accept: accepts=%0d spacing=%0d beats=%0d required 2 4 2", acc, acc2 - acc1, popped);
    end
    exp_q.delete();
    $display("back-to-back accepts at cycles %0d and %0d", acc1, acc2);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 8'h00;
      shadow[i] = 8'h00;
    end
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    test_reset();
    test_single();
    test_wrap();
    test_backpressure();
    test_write_gaps();
    test_reset_mid_read();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
